card_shoe_dealer: RTL

- Responder side of the deal handshake used by the game state machine. On `draw_card` it shuffles from a virtual 52-card shoe and deals 9 unique cards in one packed bus: player ×2, dealer ×2, community ×5.
- It then raises `all_cards_dealt` and holds the cards stable for the consumer to latch.
- Randomness comes from a free-running LFSR, so the human's button timing decorrelates successive deals.

---
 rtl/card_shoe_dealer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/card_shoe_dealer.sv
// -----------------------------------------------------------------------------
// card_shoe_dealer
//
// Purpose:
//   Responder side of the deal handshake used by the game state machine. On a
//   draw_card request it draws 9 unique cards from a virtual 52-card shoe and
//   presents them on one packed bus. The order is player x2, dealer x2, then
//   community x5 (flop, flop, flop, turn, river). It then raises
//   all_cards_dealt and holds the cards stable until the request drops.
//   Randomness comes from a free-running 16-bit Galois LFSR. The human's button
//   timing therefore decorrelates successive deals.
//
//   Card code (6 bits): [5:4] suit 0..3, [3:0] rank 0..12 (0 = deuce,
//   12 = ace). Ranks 13..15 are never dealt.
//
// Configuration:
//   FIXED_DECK_EN - when defined, every SAMPLE takes the code after the last
//                   accepted card (0x00 for the first card). A fresh deal is
//                   then 0x00..0x08. The LFSR keeps running but is ignored.
//
// Parameters:
//   SEED      - LFSR reset value; 0 is replaced by 16'hACE1
//   NUM_CARDS - cards per deal; fixed by the bus width, legal only as 9
//
// Ports:
//   clk             in   1   system clock
//   reset           in   1   asynchronous, active-high reset
//   draw_card       in   1   level request; sampled only in IDLE and DONE
//   dealt_cards     out  54  card k in bits [6k+5:6k], card MSB at bit 6k
//   all_cards_dealt out  1   all cards valid and stable
//   busy            out  1   high while sampling/checking candidates
//   deal_count      out  4   cards accepted so far this deal, 0..9
// -----------------------------------------------------------------------------
module card_shoe_dealer #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          NUM_CARDS = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        draw_card,
    output logic [53:0] dealt_cards,
    output logic        all_cards_dealt,
    output logic        busy,
    output logic [3:0]  deal_count
);

    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [3:0]  LAST_SLOT = 4'(NUM_CARDS - 1);
    localparam logic [3:0]  MAX_RANK  = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAMPLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic [5:0]  r_cand;
    logic [63:0] r_used;
    logic [3:0]  r_count;
    logic [53:0] r_dealt;
    logic        r_flag;
    logic        r_busy;
`ifdef FIXED_DECK_EN
    logic [5:0]  r_last;
`endif

    logic [15:0] w_lfsr_next;
    logic        w_cand_ok;

    // Walk the 52 legal codes in order: past the ace (or from an invalid
    // rank) wrap to the deuce of the next suit. This bounds any search to
    // at most 52 steps.
    function automatic logic [5:0] next_code(input logic [5:0] code);
        if (code[3:0] >= MAX_RANK) begin
            return {code[5:4] + 2'd1, 4'd0};
        end
        return {code[5:4], code[3:0] + 4'd1};
    endfunction

    // The bus carries each card with its MSB at the lowest bit of the field.
    function automatic logic [5:0] rev6(input logic [5:0] code);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) begin
            r[i] = code[5 - i];
        end
        return r;
    endfunction

    // Galois form: shift right, fold the taps in when a 1 falls out. A
    // nonzero state never maps to zero.
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    assign w_cand_ok   = (r_cand[3:0] <= MAX_RANK) && !r_used[r_cand];

    // The LFSR runs in every state so that request timing perturbs the deal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= SEED_EFF;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values of r_cand, r_count and r_used.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cand  <= '0;
            // NOTE: the used mask is a flop array, not a RAM, so it is cleared
            // at reset as well as at the start of every deal.
            r_used  <= '0;
            r_count <= '0;
            r_dealt <= '0;
            r_flag  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef FIXED_DECK_EN
            r_last  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    // The previous deal stays on the bus until overwritten.
                    if (draw_card) begin
                        r_used  <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SAMPLE;
                    end
                end

                S_SAMPLE: begin
`ifdef FIXED_DECK_EN
                    r_cand  <= (r_count == 4'd0) ? 6'h00 : next_code(r_last);
`else
                    r_cand  <= r_lfsr[5:0];
`endif
                    r_state <= S_CHECK;
                end

                S_CHECK: begin
                    if (w_cand_ok) begin
                        for (int k = 0; k < NUM_CARDS; k++) begin
                            if (r_count == 4'(k)) begin
                                r_dealt[6*k +: 6] <= rev6(r_cand);
                            end
                        end
                        r_used[r_cand] <= 1'b1;
                        r_count        <= r_count + 4'd1;
`ifdef FIXED_DECK_EN
                        r_last         <= r_cand;
`endif
                        if (r_count == LAST_SLOT) begin
                            r_flag  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SAMPLE;
                        end
                    end else begin
                        r_cand <= next_code(r_cand);
                    end
                end

                S_DONE: begin
                    // Holding the flag until the request drops means a new
                    // request can never observe a stale flag.
                    if (!draw_card) begin
                        r_flag  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dealt_cards     = r_dealt;
    assign all_cards_dealt = r_flag;
    assign busy            = r_busy;
    assign deal_count      = r_count;

endmodule
